// File: rtl/alu_nibble_serial.sv
// Nibble-serial 16-bit add/subtract unit for the COMET2 ALU (ADDA/SUBA/ADDL/SUBL).
// One 4-bit slice per clock with a registered carry; all outputs are registered.
module alu_nibble_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             of,
  output logic             sf,
  output logic             zf
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [1:0]       r_op;
  logic             r_cin;
  logic [IW-1:0]    r_idx;
  logic             r_of;
  logic             r_sf;
  logic             r_zf;

  logic             w_accept;
  logic             w_last;
  logic [4:0]       w_sum;
  logic [WIDTH-1:0] w_res_next;
  logic             w_of;

  // Busy is derived from the state one cycle late, so gate on it as well to
  // keep a start seen alongside the done pulse from being taken.
  assign w_accept = (r_state == S_IDLE) && start && !busy;
  assign w_last   = (r_idx == IW'(N - 1));
  assign w_sum    = {1'b0, r_a[{r_idx, 2'b00} +: 4]}
                  + {1'b0, r_b[{r_idx, 2'b00} +: 4]}
                  + {4'd0, r_cin};

  always_comb begin
    w_res_next = r_res;
    w_res_next[{r_idx, 2'b00} +: 4] = w_sum[3:0];
  end

  always_comb begin
    w_of = 1'b0;
    case (r_op)
      2'b00, 2'b01: w_of = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
      2'b10:        w_of = w_sum[4];
      2'b11:        w_of = ~w_sum[4];
      default:      w_of = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_CALC;
        else          w_next = S_IDLE;
      end
      S_CALC: begin
        if (w_last) w_next = S_DONE;
        else        w_next = S_CALC;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= {WIDTH{1'b0}};
      r_b   <= {WIDTH{1'b0}};
      r_res <= {WIDTH{1'b0}};
      r_op  <= 2'b00;
      r_cin <= 1'b0;
      r_idx <= {IW{1'b0}};
      r_of  <= 1'b0;
      r_sf  <= 1'b0;
      r_zf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_b   <= op[0] ? ~b : b;
            r_op  <= op;
            r_cin <= op[0];
            r_idx <= {IW{1'b0}};
          end
        end
        S_CALC: begin
          r_res <= w_res_next;
          r_cin <= w_sum[4];
          if (w_last) begin
            r_of <= w_of;
            r_sf <= w_res_next[WIDTH-1];
            r_zf <= (w_res_next == {WIDTH{1'b0}});
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= {WIDTH{1'b0}};
      of     <= 1'b0;
      sf     <= 1'b0;
      zf     <= 1'b0;
    end else begin
      busy   <= (r_state != S_IDLE);
      done   <= (r_state == S_DONE);
      result <= r_res;
      of     <= r_of;
      sf     <= r_sf;
      zf     <= r_zf;
    end
  end

endmodule

// File: tb/tb_alu_nibble_serial.sv
// Directed, table-driven bench for alu_nibble_serial plus hand sequences for
// the ignored-restart and mid-calculation reset cases.
module tb_alu_nibble_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        of;
  logic        sf;
  logic        zf;

  int checks = 0;
  int errors = 0;

  alu_nibble_serial #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .of(of), .sf(sf), .zf(zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        of;
    logic        sf;
    logic        zf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] er,
                        input logic eo, input logic es, input logic ez);
    int dcyc;
    int bcnt;
    dcyc = 0;
    bcnt = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y; op = ~o;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        dcyc = c;
        break;
      end
    end
    chk({nm, " latency"}, dcyc, 5);
    chk({nm, " busy_cycles"}, bcnt, 5);
    chk({nm, " result"}, {16'd0, result}, {16'd0, er});
    chk({nm, " of"}, {31'd0, of}, {31'd0, eo});
    chk({nm, " sf"}, {31'd0, sf}, {31'd0, es});
    chk({nm, " zf"}, {31'd0, zf}, {31'd0, ez});
    @(posedge clk); #1;
    chk({nm, " done_width"}, {31'd0, done}, 32'd0);
    chk({nm, " busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int dcyc;
    int stray;
    logic [15:0] res_at_done;
    logic        of_at_done;

    vecs[0] = '{"adda_ovf",   2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{"suba_zero",  2'b01, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"suba_ovf",   2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"addl_wrap",  2'b10, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{"addl_plain", 2'b10, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"subl_borr",  2'b11, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{"subl_plain", 2'b11, 16'h0002, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"suba_wrap",  2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{"adda_negov", 2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; op = 2'b00; a = 16'h0000; b = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", {16'd0, result}, 32'd0);
    chk("reset flags", {29'd0, of, sf, zf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].of, vecs[i].sf, vecs[i].zf);
    end

    // Results hold while idle.
    repeat (3) @(posedge clk);
    #1;
    chk("hold result", {16'd0, result}, 32'd0);
    chk("hold flags", {29'd0, of, sf, zf}, {29'd0, 3'b101});

    // Second start while busy is ignored.
    pulses = 0; dcyc = 0; res_at_done = 16'hxxxx; of_at_done = 1'bx;
    @(negedge clk);
    op = 2'b00; a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op = 2'b11; a = 16'h0000; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 3; c <= 14; c++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        dcyc = c;
        res_at_done = result;
        of_at_done = of;
      end
    end
    chk("restart pulses", pulses, 1);
    chk("restart latency", dcyc, 5);
    chk("restart result", {16'd0, res_at_done}, 32'h0000_0002);
    chk("restart of", {31'd0, of_at_done}, 32'd0);

    // Reset during the third CALC cycle aborts the operation.
    stray = 0;
    @(negedge clk);
    op = 2'b00; a = 16'h00FF; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", {16'd0, result}, 32'd0);
    chk("abort flags", {29'd0, of, sf, zf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    chk("abort no_done", stray, 0);

    run_op("after_abort", 2'b00, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
